// File: rtl/key_pkg.sv
// key_pkg -- shared definitions for the key_pulse_bank slice.
//   key_state_e : per-channel debounce/repeat FSM state
//   *_DEF       : default parameter values used by the bank, channel and bus
package key_pkg;

    localparam int N_DEF       = 4;
    localparam int DEB_CYC_DEF = 4;
    localparam int REP_EN_DEF  = 1;
    localparam int REP_DLY_DEF = 8;
    localparam int REP_PER_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_WAIT = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_WAIT   = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_pulse_bank_if.sv
// key_pulse_bank_if -- key bus between the key bank and its user.
//   in    : raw key levels (1 = pressed), driven by the master
//   press : one-cycle pulse per accepted press
//   rpt   : one-cycle pulse per auto-repeat event
//   rel   : one-cycle pulse per accepted release
//   held  : level, high while a key is accepted as down
// The slave modport is the key bank side.
interface key_pulse_bank_if #(
    parameter int N = key_pkg::N_DEF
);
    logic [N-1:0] in;
    logic [N-1:0] press;
    logic [N-1:0] rpt;
    logic [N-1:0] rel;
    logic [N-1:0] held;

    modport master (output in, input press, rpt, rel, held);
    modport slave  (input in, output press, rpt, rel, held);
endinterface

// File: rtl/key_channel.sv
// key_channel -- one debounced key with press/release/auto-repeat pulses.
//   clk, reset : system clock, asynchronous active-high reset
//   in         : raw unsynchronised key level
//   press      : one-cycle pulse when a press is accepted
//   rpt        : one-cycle auto-repeat pulse while held
//   rel        : one-cycle pulse when a release is accepted
//   held       : high while the key is accepted as down (HELD or REL_WAIT)
module key_channel
    import key_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int REP_EN  = REP_EN_DEF,
    parameter int REP_DLY = REP_DLY_DEF,
    parameter int REP_PER = REP_PER_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic press,
    output logic rpt,
    output logic rel,
    output logic held
);

    localparam int CNT_W   = $clog2(DEB_CYC);
    localparam int TMR_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REP_DLY - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REP_PER - 1);

    logic             sync1;
    logic             s;
    key_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [TMR_W-1:0] tmr, tmr_nx;
    // rep_on selects the repeat period once the initial delay has elapsed,
    // so the timer only ever counts up to the active limit and reloads to 0.
    logic             rep_on, rep_on_nx;
    logic             press_nx, rpt_nx, rel_nx;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        tmr_nx    = tmr;
        rep_on_nx = rep_on;
        press_nx  = 1'b0;
        rpt_nx    = 1'b0;
        rel_nx    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s) begin
                    state_nx = ST_PRESS_WAIT;
                    cnt_nx   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx  = ST_HELD;
                    cnt_nx    = '0;
                    press_nx  = 1'b1;
                    tmr_nx    = '0;
                    rep_on_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                // The timer only advances on cycles that stay in HELD, so a
                // bounce through REL_WAIT pauses the repeat cadence.
                if (!s) begin
                    state_nx = ST_REL_WAIT;
                    cnt_nx   = CNT_ONE;
                end else if (tmr == (rep_on ? PER_LAST : DLY_LAST)) begin
                    tmr_nx    = '0;
                    rep_on_nx = 1'b1;
                    rpt_nx    = (REP_EN != 0);
                end else begin
                    tmr_nx = tmr + TMR_ONE;
                end
            end
            ST_REL_WAIT: begin
                if (s) begin
                    state_nx = ST_HELD;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    rel_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            s      <= 1'b0;
            state  <= ST_IDLE;
            cnt    <= '0;
            tmr    <= '0;
            rep_on <= 1'b0;
            press  <= 1'b0;
            rpt    <= 1'b0;
            rel    <= 1'b0;
            held   <= 1'b0;
        end else begin
            sync1  <= in;
            s      <= sync1;
            state  <= state_nx;
            cnt    <= cnt_nx;
            tmr    <= tmr_nx;
            rep_on <= rep_on_nx;
            press  <= press_nx;
            rpt    <= rpt_nx;
            rel    <= rel_nx;
            held   <= (state_nx == ST_HELD) || (state_nx == ST_REL_WAIT);
        end
    end

endmodule

// File: rtl/key_pulse_bank.sv
// key_pulse_bank -- N independent debounced key channels.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : key bus (slave side); in[i] raw level, press/rpt/rel
//                pulses and held level per channel
// The interface instance must be built with the same N as this module.
module key_pulse_bank
    import key_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int REP_EN  = REP_EN_DEF,
    parameter int REP_DLY = REP_DLY_DEF,
    parameter int REP_PER = REP_PER_DEF
) (
    input  logic             clk,
    input  logic             reset,
    key_pulse_bank_if.slave  bus
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        key_channel #(
            .DEB_CYC (DEB_CYC),
            .REP_EN  (REP_EN),
            .REP_DLY (REP_DLY),
            .REP_PER (REP_PER)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .in    (bus.in[i]),
            .press (bus.press[i]),
            .rpt   (bus.rpt[i]),
            .rel   (bus.rel[i]),
            .held  (bus.held[i])
        );
    end

endmodule

// File: tb/tb_key_pulse_bank.sv
// tb_key_pulse_bank -- directed bench for key_pulse_bank (N=4, DEB_CYC=4,
// REP_DLY=8, REP_PER=3). Expected pulses are derived from the key timing
// (press DEB_CYC+1 edges after the first high sample, repeats counted over
// edges that stay in HELD, release DEB_CYC+1 edges after the first low
// sample) and queued when the stimulus is planned; the monitor pops them
// as the DUT pulses. A second instance built with REP_EN=0 shares inputs.
module tb_key_pulse_bank;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int DLY = 8;
    localparam int PER = 3;

    localparam int K_PRESS = 0;
    localparam int K_RPT   = 1;
    localparam int K_REL   = 2;
    localparam int K_HON   = 3;
    localparam int K_HOFF  = 4;

    typedef struct {
        int e;
        int kind;
        int ch;
    } ev_t;

    logic clk = 1'b0;
    logic reset;

    key_pulse_bank_if #(.N(N)) bus1 ();
    key_pulse_bank_if #(.N(N)) bus2 ();

    assign bus2.in = bus1.in;

    key_pulse_bank #(
        .N(N), .DEB_CYC(DEB), .REP_EN(1), .REP_DLY(DLY), .REP_PER(PER)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    key_pulse_bank #(
        .N(N), .DEB_CYC(DEB), .REP_EN(0), .REP_DLY(DLY), .REP_PER(PER)
    ) dut_norep (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    ev_t          q[$];
    int           edge_n;
    int           n_pass;
    int           n_checks;
    logic [N-1:0] exp_held;
    int           e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, edge_n);
    endtask

    task automatic push(input int pe, input int kind, input int ch);
        ev_t t;
        t.e    = pe;
        t.kind = kind;
        t.ch   = ch;
        q.push_back(t);
    endtask

    // Key ch first sampled high at edge pe, first sampled low at edge r
    // (r+1 is the last edge still seen high), optional one-sample low
    // glitch at edge g (-1 for none).
    task automatic plan(input int ch, input int pe, input int r, input int g, input bit has_rel);
        int h;
        int c;
        h = pe + DEB + 1;
        push(h, K_PRESS, ch);
        push(h, K_HON, ch);
        c = 0;
        for (int t = h + 1; t <= r + 1; t++) begin
            if (g >= 0 && (t == g + 2 || t == g + 3)) continue;
            c++;
            if (c == DLY || (c > DLY && ((c - DLY) % PER) == 0))
                push(t, K_RPT, ch);
        end
        if (has_rel) begin
            push(r + DEB + 1, K_REL, ch);
            push(r + DEB + 1, K_HOFF, ch);
        end
    endtask

    task automatic monitor();
        logic [N-1:0] pv;
        int           missed;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].e == edge_n && q[i].kind >= K_HON) begin
                exp_held[q[i].ch] = (q[i].kind == K_HON);
                q.delete(i);
            end
        end
        chk("held", 32'(bus1.held), 32'(exp_held));
        for (int k = 0; k < 3; k++) begin
            pv = (k == K_PRESS) ? bus1.press : (k == K_RPT) ? bus1.rpt : bus1.rel;
            for (int c = 0; c < N; c++) begin
                if (pv[c]) begin
                    int idx;
                    idx = -1;
                    foreach (q[i])
                        if (idx < 0 && q[i].e == edge_n && q[i].kind == k && q[i].ch == c)
                            idx = i;
                    n_checks++;
                    assert (idx >= 0) n_pass++;
                    else $error("FAIL pulse kind%0d ch%0d edge %0d: observed 1 expected 0", k, c, edge_n);
                    if (idx >= 0) q.delete(idx);
                end
            end
        end
        missed = 0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].e <= edge_n && q[i].kind < K_HON) begin
                $display("  missing pulse kind%0d ch%0d due edge %0d", q[i].kind, q[i].ch, q[i].e);
                missed++;
                q.delete(i);
            end
        end
        chk("missed_pulses", 32'(missed), 32'd0);
        chk("norep_rpt", 32'(bus2.rpt), 32'd0);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            monitor();
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus1.in  = '0;
        exp_held = '0;
        edge_n   = 0;
        n_pass   = 0;
        n_checks = 0;
        repeat (3) @(negedge clk);
        chk("rst_press", 32'(bus1.press), 32'd0);
        chk("rst_rpt",   32'(bus1.rpt),   32'd0);
        chk("rst_rel",   32'(bus1.rel),   32'd0);
        chk("rst_held",  32'(bus1.held),  32'd0);
        reset = 1'b0;

        // Channels 0 and 2 pressed, channel 1 bounces for two samples.
        e = edge_n + 1;
        plan(0, e, e + 20, -1, 1'b1);
        plan(2, e, e + 40, e + 25, 1'b1);
        bus1.in = 4'b0111;
        step(2);
        bus1.in[1] = 1'b0;
        step(18);
        bus1.in[0] = 1'b0;
        step(5);
        bus1.in[2] = 1'b0;
        step(1);
        bus1.in[2] = 1'b1;
        step(14);
        bus1.in[2] = 1'b0;
        step(12);

        // Channel 3 held, then reset pulsed between edges.
        e = edge_n + 1;
        plan(3, e, e + 8, -1, 1'b0);
        bus1.in[3] = 1'b1;
        step(10);
        chk("held3_before_reset", 32'(bus1.held), 32'h8);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_press", 32'(bus1.press), 32'd0);
        chk("async_rst_rpt",   32'(bus1.rpt),   32'd0);
        chk("async_rst_rel",   32'(bus1.rel),   32'd0);
        chk("async_rst_held",  32'(bus1.held),  32'd0);
        #1 reset = 1'b0;
        exp_held = '0;
        e = edge_n + 1;
        plan(3, e, e + 15, -1, 1'b1);
        step(15);
        bus1.in[3] = 1'b0;
        step(10);

        // All channels together.
        e = edge_n + 1;
        for (int c = 0; c < N; c++) plan(c, e, e + 10, -1, 1'b1);
        bus1.in = 4'b1111;
        step(6);
        chk("press_all", 32'(bus1.press), 32'hF);
        step(4);
        bus1.in = 4'b0000;
        step(12);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
